// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave
//   AHB-Lite responder backed by an internal word-addressed SRAM.
//   Inserts WAIT_STATES stall cycles in every OKAY data phase. Supports
//   byte, halfword and word writes through byte-lane merging. Out-of-range,
//   misaligned and oversize accesses get a two-cycle ERROR response.
//
// Ports
//   HCLK       in   clock, rising edge
//   HRESET     in   synchronous active-high reset
//   HSEL       in   slave select
//   HADDR      in   [31:0] byte address (address phase)
//   HTRANS     in   [1:0]  IDLE/BUSY/NONSEQ/SEQ
//   HWRITE     in   1 = write
//   HSIZE      in   [2:0]  byte/halfword/word
//   HWDATA     in   [31:0] write data (data phase)
//   HREADY     in   bus-level ready
//   HRDATA     out  [31:0] registered read data
//   HREADYOUT  out  slave ready
//   HRESP      out  0 = OKAY, 1 = ERROR
module ahb_sram_slave #(
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int unsigned IW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [32:0] MEM_BYTES = 33'(MEM_DEPTH) * 33'd4;
    localparam logic [3:0]  WS_LOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [31:0]     r_mem [0:MEM_DEPTH-1];
    logic [IW-1:0]   r_idx;
    logic [1:0]      r_lane;
    logic [1:0]      r_size;
    logic            r_write;
    logic [3:0]      r_wcnt;
    logic [31:0]     r_rdata;

    logic [31:0]     w_offset;
    logic [IW-1:0]   w_idx;
    logic            w_slot;
    logic            w_accept;
    logic            w_err;
    logic [3:0]      w_be;
    logic            w_wr_en;
    logic [31:0]     w_merged;
    logic [IW-1:0]   w_rd_idx;
    logic            w_rd_load;
    logic [31:0]     w_rd_word;
    logic            w_unused;

    assign w_unused = HTRANS[0];

    assign w_offset = HADDR - BASE_ADDR;
    assign w_idx    = w_offset[IW+1:2];

    // Address phases are only sampled in states that drive HREADYOUT high.
    assign w_slot   = (r_state == S_IDLE) || (r_state == S_DATA) || (r_state == S_ERR2);
    assign w_accept = HSEL & HREADY & HTRANS[1] & w_slot;

    assign w_err = ({1'b0, w_offset} >= MEM_BYTES)
                 | (HSIZE > 3'b010)
                 | ((HSIZE == 3'b001) & HADDR[0])
                 | ((HSIZE == 3'b010) & (HADDR[1:0] != 2'b00));

    always_comb begin
        w_be = 4'b0000;
        unique case (r_size)
            2'b00:   w_be = 4'b0001 << r_lane;
            2'b01:   w_be = r_lane[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    assign w_wr_en = (r_state == S_DATA) & r_write;

    always_comb begin
        w_merged = r_mem[r_idx];
        for (int unsigned i = 0; i < 4; i++) begin
            if (w_be[i]) begin
                w_merged[8*i +: 8] = HWDATA[8*i +: 8];
            end
        end
    end

    // In WAIT the read comes from the latched address; otherwise the read is
    // being accepted right now (zero wait states) and uses the live address.
    // A write finishing at the same edge to the same word is forwarded.
    assign w_rd_idx  = (r_state == S_WAIT) ? r_idx : w_idx;
    assign w_rd_load = (w_next == S_DATA) && ((r_state == S_WAIT) ? !r_write : !HWRITE);
    assign w_rd_word = (w_wr_en && (w_rd_idx == r_idx)) ? w_merged : r_mem[w_rd_idx];

    always_comb begin
        w_next    = r_state;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        unique case (r_state)
            S_IDLE: ;
            S_WAIT: begin
                HREADYOUT = 1'b0;
                if (r_wcnt == 4'd0) begin
                    w_next = S_DATA;
                end
            end
            S_DATA: ;
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                w_next    = S_ERR2;
            end
            S_ERR2: begin
                HRESP = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_slot) begin
            if (w_accept) begin
                if (w_err) begin
                    w_next = S_ERR1;
                end else if (WAIT_STATES > 0) begin
                    w_next = S_WAIT;
                end else begin
                    w_next = S_DATA;
                end
            end else begin
                w_next = S_IDLE;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_lane  <= '0;
            r_size  <= '0;
            r_write <= 1'b0;
            r_wcnt  <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_idx   <= w_idx;
                r_lane  <= HADDR[1:0];
                r_size  <= HSIZE[1:0];
                r_write <= HWRITE;
            end
            if (w_accept && !w_err) begin
                r_wcnt <= WS_LOAD;
            end else if ((r_state == S_WAIT) && (r_wcnt != 4'd0)) begin
                r_wcnt <= r_wcnt - 4'd1;
            end
            if (w_rd_load) begin
                r_rdata <= w_rd_word;
            end
        end
    end

    // Contents survive reset; only the write itself is blocked.
    always_ff @(posedge HCLK) begin
        if (!HRESET && w_wr_en) begin
            r_mem[r_idx] <= w_merged;
        end
    end

    assign HRDATA = r_rdata;

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB-Lite responder (slave) backed by an internal word-addressed SRAM array.
- Sits on the far end of the bus from `ahb_master` and completes its write and read transfers.
- Supports a fixed, programmable number of wait states, byte/halfword/word writes, and a two-cycle ERROR response for out-of-range or misaligned accesses.
- Serves as the standard memory target for system-level simulation of the master.

Parameters:
- MEM_DEPTH, 256: number of 32-bit words; the valid byte range is 0 to MEM_DEPTH*4-1.
- WAIT_STATES, 1: HREADYOUT-low cycles inserted in each OKAY data phase; legal range 0..15.
- BASE_ADDR, 32'h0000_0000: base byte address; accesses are decoded at HADDR minus BASE_ADDR.

Ports:
- HCLK       in   1   clock; all logic updates on its rising edge.
- HRESET     in   1   reset; synchronous, active-high.
- HSEL       in   1   slave select from the decoder.
- HADDR      in   32  byte address, sampled in the address phase.
- HTRANS     in   2   00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE     in   1   1 = write, 0 = read.
- HSIZE      in   3   000 byte, 001 halfword, 010 word; any other value is an error.
- HWDATA     in   32  write data, valid in the data phase.
- HREADY     in   1   bus-level ready; qualifies address-phase sampling.
- HRDATA     out  32  read data.
- HREADYOUT  out  1   slave ready.
- HRESP      out  1   0 = OKAY, 1 = ERROR.

Behaviour:
- Reset: while HRESET=1 at a clock edge:
  - HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0.
  - Any pending write is discarded.
  - SRAM contents are not cleared.
- Address-phase acceptance: a transfer is accepted when HSEL & HREADY & HTRANS[1] are all high at the clock edge. At acceptance the block latches HADDR, HWRITE and HSIZE.
- IDLE/BUSY or unselected transfers: zero-wait OKAY; HREADYOUT=1, HRESP=0, no state change.
- Error check at acceptance: an access is an error if any of the following hold:
  - offset (HADDR-BASE_ADDR) ≥ MEM_DEPTH*4
  - HSIZE > 010
  - halfword access with HADDR[0]=1
  - word access with HADDR[1:0]≠00
- FSM states:
  - IDLE: HREADYOUT=1. An accepted OK access goes to WAIT if WAIT_STATES>0, otherwise to DATA. An accepted error goes to ERR1.
  - WAIT: HREADYOUT=0, HRESP=0. The counter loads WAIT_STATES-1 on entry and decrements each cycle; at 0 go to DATA.
  - DATA: HREADYOUT=1, HRESP=0; the transfer completes at the end of this cycle.
    - Write: HWDATA is sampled at this edge and merged into the SRAM by byte lanes, selected by the latched HSIZE and address[1:0] (little-endian, lane n = bits 8n+7:8n).
    - Read: HRDATA holds the full 32-bit word for the whole cycle.
    - A new transfer accepted at the same edge follows the IDLE rules.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1. The SRAM is never written for an error transfer; HRDATA is held.
    - If the master cancels the next transfer (HTRANS=IDLE in ERR1), a transfer seen in ERR2 is still accepted normally.
- Read data timing: HRDATA is registered and updated only when entering DATA for a read. It holds its value otherwise, including during WAIT and after writes.
- Read-after-write hazard: when a read is accepted in the same cycle a write completes in DATA to the same word, the read must return the merged new value (forwarding), never the stale word.
- Address wrap: the word index is offset[log2(MEM_DEPTH)+1:2]. No wrap-around is permitted, because out-of-range offsets always take the ERROR path.
- HREADY low while idle: no acceptance; the block stays IDLE.

Test Plan:
- Reset: assert HRESET 2 cycles mid-WAIT of a write to 0x10 of 0xDEADBEEF -> HREADYOUT=1, HRESP=0, HRDATA=0; a subsequent read of 0x10 does not return 0xDEADBEEF.
- Basic write then read with WAIT_STATES=1: write 0xDEADBEEF to 0x10, then read 0x10 -> each data phase shows exactly 1 cycle of HREADYOUT=0; HRDATA=0xDEADBEEF with HRESP=0.
- Byte lanes: word-write 0x11223344 to 0x20; byte-write 0xAA to 0x21; halfword-write 0xBBCC (on HWDATA[31:16]) to 0x22; read 0x20 -> 0xBBCCAA44.
- Back-to-back forwarding: write 0xCAFEF00D to 0x40 with a read of 0x40 issued in the write's final data cycle -> read returns 0xCAFEF00D.
- Errors:
  - Word read at 0x402 (misaligned) -> HREADYOUT 0 then 1, HRESP=1 for both cycles.
  - Write at 0x400 with MEM_DEPTH=256 -> ERROR response; the SRAM is unchanged.
- Idle/unselected traffic: HSEL=0 with HTRANS=NONSEQ, then HSEL=1 with HTRANS=IDLE -> HREADYOUT stays 1, HRESP=0, no SRAM change, HRDATA held.
